// File: rtl/capsule_coupling_normalizer_if.sv
// capsule_coupling_normalizer_if
//   Groups the three handshakes of the coupling normalizer into one bundle.
//   Ports (seen from the normalizer, slave modport):
//     in_valid/in_ready/in_data          exponent input stream
//     div_start/div_a/div_b/div_d/div_ok shared 32-bit sequential divider
//     out_valid/out_ready/out_data/out_last/out_zero  coefficient stream
//   The master modport is the surrounding environment.
interface capsule_coupling_normalizer_if #(
  parameter int IW = 16
);
  logic          in_valid;
  logic          in_ready;
  logic [IW-1:0] in_data;
  logic          div_start;
  logic [31:0]   div_a;
  logic [31:0]   div_b;
  logic [31:0]   div_d;
  logic          div_ok;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_data;
  logic          out_last;
  logic          out_zero;

  modport master (
    output in_valid, in_data, div_d, div_ok, out_ready,
    input  in_ready, div_start, div_a, div_b, out_valid, out_data, out_last, out_zero
  );

  modport slave (
    input  in_valid, in_data, div_d, div_ok, out_ready,
    output in_ready, div_start, div_a, div_b, out_valid, out_data, out_last, out_zero
  );
endinterface

// File: rtl/capsule_coupling_normalizer.sv
// capsule_coupling_normalizer
//   Final softmax normalisation of the dynamic-routing datapath. Collects N
//   unsigned exponent values, sums them, then uses the shared sequential
//   divider to emit c_i = e_i / sum in unsigned Q16.16, one per handshake,
//   with out_last on the N-th coefficient. A zero sum never starts the
//   divider; the group is emitted as zeros with out_zero set.
//   Ports:
//     clk    rising-edge clock
//     reset  asynchronous active-low reset
//     bus    capsule_coupling_normalizer_if slave modport (input, divider
//            and output handshakes)
module capsule_coupling_normalizer #(
  parameter int N    = 8,
  parameter int IW   = 16,
  parameter int FRAC = 16
) (
  input  logic clk,
  input  logic reset,
  capsule_coupling_normalizer_if.slave bus
);

  localparam int CW   = $clog2(N + 1);
  localparam int IDXW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(N - 1);
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(N - 1);

  localparam logic [1:0] COLLECT = 2'd0;
  localparam logic [1:0] ISSUE   = 2'd1;
  localparam logic [1:0] WAIT    = 2'd2;
  localparam logic [1:0] EMIT    = 2'd3;

  logic [1:0]      state;
  logic [CW-1:0]   cnt;
  logic [IDXW-1:0] idx;
  logic [31:0]     sum;
  logic [IW-1:0]   vbuf [N];
  logic            zflag;
  logic            alive;
  logic [31:0]     out_data_q;

  logic            accept;
  logic            handshake;
  logic [31:0]     sum_next;
  logic [IDXW-1:0] wr_ptr;

  assign accept    = bus.in_valid && bus.in_ready;
  assign handshake = bus.out_valid && bus.out_ready;
  assign sum_next  = sum + {{(32 - IW){1'b0}}, bus.in_data};
  assign wr_ptr    = cnt[IDXW-1:0];

  // alive keeps in_ready low while reset is held and for the reset cycle
  // itself; in_ready only rises on the first clock after release.
  assign bus.in_ready  = alive && (state == COLLECT);
  // In WAIT the start line follows ~div_ok so the divider keeps running
  // but does not reload on the cycle its result becomes visible.
  assign bus.div_start = (state == ISSUE) || ((state == WAIT) && !bus.div_ok);
  assign bus.div_a     = {vbuf[idx], {FRAC{1'b0}}};
  assign bus.div_b     = sum;
  assign bus.out_valid = (state == EMIT);
  assign bus.out_last  = (state == EMIT) && (idx == IDX_LAST);
  assign bus.out_zero  = (state == EMIT) && zflag;
  assign bus.out_data  = out_data_q;

  // Value buffer: each accepted exponent lands at the current fill index
  // and stays there until the group has been fully emitted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N; i++) vbuf[i] <= '0;
    end else if (accept) begin
      vbuf[wr_ptr] <= bus.in_data;
    end
  end

  // Control FSM: collect N values, then per coefficient issue a division,
  // wait for the divider, and hold the result until downstream takes it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= COLLECT;
      cnt        <= '0;
      idx        <= '0;
      sum        <= '0;
      zflag      <= 1'b0;
      alive      <= 1'b0;
      out_data_q <= '0;
    end else begin
      alive <= 1'b1;
      case (state)
        COLLECT: begin
          if (accept) begin
            sum <= sum_next;
            cnt <= cnt + 1'b1;
            if (cnt == CNT_LAST) begin
              idx <= '0;
              // An all-zero group skips the divider entirely.
              if (sum_next == 32'd0) begin
                zflag      <= 1'b1;
                out_data_q <= '0;
                state      <= EMIT;
              end else begin
                state <= ISSUE;
              end
            end
          end
        end
        ISSUE: begin
          state <= WAIT;
        end
        WAIT: begin
          if (bus.div_ok) begin
            out_data_q <= bus.div_d;
            state      <= EMIT;
          end
        end
        EMIT: begin
          if (handshake) begin
            if (idx == IDX_LAST) begin
              cnt   <= '0;
              idx   <= '0;
              sum   <= '0;
              zflag <= 1'b0;
              state <= COLLECT;
            end else begin
              idx <= idx + 1'b1;
              if (zflag) begin
                out_data_q <= '0;
              end else begin
                state <= ISSUE;
              end
            end
          end
        end
        default: begin
          state <= COLLECT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_capsule_coupling_normalizer.sv
// tb_capsule_coupling_normalizer
//   Self-checking bench: an N=4 and an N=1 instance, each with a behavioural
//   32-cycle sequential divider. Expected coefficients are queued when a
//   group is driven and popped as the DUT presents each output.
module tb_capsule_coupling_normalizer;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
    logic        zero;
  } exp_t;

  logic clk;
  logic reset;

  int passCount;
  int checkCount;
  int cyc;
  int issueCyc;
  logic prevStart;

  exp_t expQ[$];

  capsule_coupling_normalizer_if #(.IW(16)) bus4 ();
  capsule_coupling_normalizer_if #(.IW(16)) bus1 ();

  capsule_coupling_normalizer #(.N(4), .IW(16), .FRAC(16)) dut4 (
    .clk(clk), .reset(reset), .bus(bus4)
  );
  capsule_coupling_normalizer #(.N(1), .IW(16), .FRAC(16)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1)
  );

  // Clock and cycle counter.
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Divider model for the N=4 instance: loads on start while idle, stays
  // busy for 32 cycles showing a junk quotient, then presents a/b.
  logic        busy4;
  logic [4:0]  cnt4;
  logic [31:0] q4;
  logic [31:0] pend4;
  int          starts4;
  int          zeroDiv;
  assign bus4.div_ok = !busy4;
  assign bus4.div_d  = q4;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy4 <= 1'b0; cnt4 <= '0; q4 <= '0; pend4 <= '0;
    end else if (!busy4) begin
      if (bus4.div_start) begin
        busy4   <= 1'b1;
        cnt4    <= 5'd31;
        q4      <= 32'hDEAD_BEEF;
        pend4   <= (bus4.div_b == 0) ? 32'd0 : bus4.div_a / bus4.div_b;
        starts4 <= starts4 + 1;
        if (bus4.div_b == 0) zeroDiv <= zeroDiv + 1;
      end
    end else if (cnt4 == 0) begin
      busy4 <= 1'b0;
      q4    <= pend4;
    end else begin
      cnt4 <= cnt4 - 1'b1;
    end
  end

  // Same divider model for the N=1 instance.
  logic        busy1;
  logic [4:0]  cnt1;
  logic [31:0] q1;
  logic [31:0] pend1;
  assign bus1.div_ok = !busy1;
  assign bus1.div_d  = q1;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy1 <= 1'b0; cnt1 <= '0; q1 <= '0; pend1 <= '0;
    end else if (!busy1) begin
      if (bus1.div_start) begin
        busy1 <= 1'b1;
        cnt1  <= 5'd31;
        q1    <= 32'hDEAD_BEEF;
        pend1 <= (bus1.div_b == 0) ? 32'd0 : bus1.div_a / bus1.div_b;
        if (bus1.div_b == 0) zeroDiv <= zeroDiv + 1;
      end
    end else if (cnt1 == 0) begin
      busy1 <= 1'b0;
      q1    <= pend1;
    end else begin
      cnt1 <= cnt1 - 1'b1;
    end
  end

  // Remember the cycle at which each division is issued (rising div_start).
  always @(negedge clk) begin
    if (bus4.div_start && !prevStart) issueCyc <= cyc;
    prevStart <= bus4.div_start;
  end

  // Drive one group of four values, first value in vals[15:0].
  task automatic sendGroup4(input logic [63:0] vals);
    for (int i = 0; i < 4; i++) begin
      int g;
      g = 0;
      bus4.in_valid = 1'b1;
      bus4.in_data  = vals[16*i +: 16];
      while (!bus4.in_ready && g < 100) begin
        @(negedge clk);
        g++;
      end
      if (!bus4.in_ready) begin
        checkCount++;
        $display("[TB] FAIL accept_timeout: in_ready=%b required 1", bus4.in_ready);
      end
      @(negedge clk);
    end
    bus4.in_valid = 1'b0;
  endtask

  // Wait (bounded) for out_valid on the N=4 instance.
  task automatic waitOut4();
    int g;
    g = 0;
    while (!bus4.out_valid && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (!bus4.out_valid) begin
      checkCount++;
      $display("[TB] FAIL out_timeout: out_valid=%b required 1", bus4.out_valid);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checkCount++;
    if ({bus4.in_ready, bus4.div_start, bus4.out_valid, bus4.out_last, bus4.out_zero} !== 5'b0)
      $display("[TB] FAIL reset_ctrl4: got %b required 00000",
               {bus4.in_ready, bus4.div_start, bus4.out_valid, bus4.out_last, bus4.out_zero});
    else passCount++;
    checkCount++;
    if (bus4.out_data !== 32'd0)
      $display("[TB] FAIL reset_data4: got %h required 00000000", bus4.out_data);
    else passCount++;
    checkCount++;
    if ({bus1.in_ready, bus1.out_valid, bus1.out_last} !== 3'b0)
      $display("[TB] FAIL reset_ctrl1: got %b required 000",
               {bus1.in_ready, bus1.out_valid, bus1.out_last});
    else passCount++;
    reset = 1'b1;
    @(negedge clk);
    checkCount++;
    if ({bus4.in_ready, bus1.in_ready} !== 2'b11)
      $display("[TB] FAIL release_in_ready: got %b required 11", {bus4.in_ready, bus1.in_ready});
    else passCount++;
  endtask

  task automatic test_uniform();
    exp_t e;
    for (int k = 0; k < 4; k++) expQ.push_back('{32'h0000_4000, (k == 3), 1'b0});
    sendGroup4({16'd1, 16'd1, 16'd1, 16'd1});
    for (int k = 0; k < 4; k++) begin
      waitOut4();
      e = expQ.pop_front();
      checkCount++;
      if (bus4.out_data !== e.data)
        $display("[TB] FAIL uniform_data[%0d]: got %h required %h", k, bus4.out_data, e.data);
      else passCount++;
      checkCount++;
      if ({bus4.out_last, bus4.out_zero} !== {e.last, e.zero})
        $display("[TB] FAIL uniform_flags[%0d]: got %b required %b", k,
                 {bus4.out_last, bus4.out_zero}, {e.last, e.zero});
      else passCount++;
      checkCount++;
      if (cyc - issueCyc != 34)
        $display("[TB] FAIL uniform_latency[%0d]: got %0d required 34", k, cyc - issueCyc);
      else passCount++;
      @(negedge clk);
    end
  endtask

  task automatic test_mixed();
    exp_t e;
    int s0;
    s0 = starts4;
    expQ.push_back('{32'h0000_C000, 1'b0, 1'b0});
    expQ.push_back('{32'h0000_4000, 1'b0, 1'b0});
    expQ.push_back('{32'h0000_0000, 1'b0, 1'b0});
    expQ.push_back('{32'h0000_0000, 1'b1, 1'b0});
    sendGroup4({16'd0, 16'd0, 16'd1, 16'd3});
    for (int k = 0; k < 4; k++) begin
      waitOut4();
      e = expQ.pop_front();
      checkCount++;
      if ({bus4.out_data, bus4.out_last, bus4.out_zero} !== {e.data, e.last, e.zero})
        $display("[TB] FAIL mixed_out[%0d]: got %h/%b/%b required %h/%b/%b", k,
                 bus4.out_data, bus4.out_last, bus4.out_zero, e.data, e.last, e.zero);
      else passCount++;
      @(negedge clk);
    end
    checkCount++;
    if (starts4 - s0 != 4)
      $display("[TB] FAIL mixed_div_starts: got %0d required 4", starts4 - s0);
    else passCount++;
  endtask

  task automatic test_zero();
    exp_t e;
    int s0;
    s0 = starts4;
    for (int k = 0; k < 4; k++) expQ.push_back('{32'h0, (k == 3), 1'b1});
    sendGroup4(64'd0);
    for (int k = 0; k < 4; k++) begin
      waitOut4();
      e = expQ.pop_front();
      checkCount++;
      if ({bus4.out_data, bus4.out_last, bus4.out_zero} !== {e.data, e.last, e.zero})
        $display("[TB] FAIL zero_out[%0d]: got %h/%b/%b required %h/%b/%b", k,
                 bus4.out_data, bus4.out_last, bus4.out_zero, e.data, e.last, e.zero);
      else passCount++;
      @(negedge clk);
    end
    checkCount++;
    if (starts4 != s0)
      $display("[TB] FAIL zero_div_starts: got %0d required 0", starts4 - s0);
    else passCount++;
  endtask

  task automatic test_stall();
    exp_t e;
    for (int k = 0; k < 4; k++) expQ.push_back('{32'h0000_4000, (k == 3), 1'b0});
    sendGroup4({16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF});
    for (int k = 0; k < 4; k++) begin
      if (k == 1) bus4.out_ready = 1'b0;
      waitOut4();
      e = expQ.pop_front();
      checkCount++;
      if ({bus4.out_data, bus4.out_last, bus4.out_zero} !== {e.data, e.last, e.zero})
        $display("[TB] FAIL stall_out[%0d]: got %h/%b/%b required %h/%b/%b", k,
                 bus4.out_data, bus4.out_last, bus4.out_zero, e.data, e.last, e.zero);
      else passCount++;
      checkCount++;
      if (bus4.in_ready !== 1'b0)
        $display("[TB] FAIL stall_in_ready[%0d]: got %b required 0", k, bus4.in_ready);
      else passCount++;
      if (k == 1) begin
        for (int s = 0; s < 5; s++) begin
          @(negedge clk);
          checkCount++;
          if ({bus4.out_valid, bus4.out_data, bus4.out_last} !== {1'b1, e.data, e.last})
            $display("[TB] FAIL stall_hold[%0d]: got %b/%h/%b required 1/%h/%b", s,
                     bus4.out_valid, bus4.out_data, bus4.out_last, e.data, e.last);
          else passCount++;
        end
        bus4.out_ready = 1'b1;
      end
      @(negedge clk);
    end
    checkCount++;
    if (bus4.in_ready !== 1'b1)
      $display("[TB] FAIL stall_in_ready_after: got %b required 1", bus4.in_ready);
    else passCount++;
  endtask

  task automatic test_reset_midop();
    exp_t e;
    int g;
    expQ.push_back('{32'h0000_1999, 1'b0, 1'b0});
    expQ.push_back('{32'h0000_3333, 1'b0, 1'b0});
    sendGroup4({16'd4, 16'd3, 16'd2, 16'd1});
    waitOut4();
    e = expQ.pop_front();
    checkCount++;
    if (bus4.out_data !== e.data)
      $display("[TB] FAIL midop_first: got %h required %h", bus4.out_data, e.data);
    else passCount++;
    @(negedge clk);
    g = 0;
    while (!bus4.div_start && g < 20) begin
      @(negedge clk);
      g++;
    end
    repeat (10) @(negedge clk);
    checkCount++;
    if ({bus4.div_start, bus4.out_valid} !== 2'b10)
      $display("[TB] FAIL midop_in_wait: got %b required 10", {bus4.div_start, bus4.out_valid});
    else passCount++;
    #2 reset = 1'b0;
    #1;
    expQ.delete();
    checkCount++;
    if ({bus4.in_ready, bus4.div_start, bus4.out_valid, bus4.out_last, bus4.out_zero} !== 5'b0)
      $display("[TB] FAIL midop_reset_ctrl: got %b required 00000",
               {bus4.in_ready, bus4.div_start, bus4.out_valid, bus4.out_last, bus4.out_zero});
    else passCount++;
    checkCount++;
    if (bus4.out_data !== 32'd0)
      $display("[TB] FAIL midop_reset_data: got %h required 00000000", bus4.out_data);
    else passCount++;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkCount++;
    if (bus4.in_ready !== 1'b1)
      $display("[TB] FAIL midop_release: got %b required 1", bus4.in_ready);
    else passCount++;
    expQ.push_back('{32'h0000_4000, 1'b0, 1'b0});
    expQ.push_back('{32'h0000_4000, 1'b0, 1'b0});
    expQ.push_back('{32'h0000_8000, 1'b0, 1'b0});
    expQ.push_back('{32'h0000_0000, 1'b1, 1'b0});
    sendGroup4({16'd0, 16'd4, 16'd2, 16'd2});
    for (int k = 0; k < 4; k++) begin
      waitOut4();
      e = expQ.pop_front();
      checkCount++;
      if ({bus4.out_data, bus4.out_last, bus4.out_zero} !== {e.data, e.last, e.zero})
        $display("[TB] FAIL midop_out[%0d]: got %h/%b/%b required %h/%b/%b", k,
                 bus4.out_data, bus4.out_last, bus4.out_zero, e.data, e.last, e.zero);
      else passCount++;
      @(negedge clk);
    end
  endtask

  task automatic test_single();
    exp_t e;
    int g;
    expQ.push_back('{32'h0001_0000, 1'b1, 1'b0});
    bus1.in_valid = 1'b1;
    bus1.in_data  = 16'h1234;
    g = 0;
    while (!bus1.in_ready && g < 100) begin
      @(negedge clk);
      g++;
    end
    @(negedge clk);
    bus1.in_valid = 1'b0;
    g = 0;
    while (!bus1.out_valid && g < 200) begin
      @(negedge clk);
      g++;
    end
    e = expQ.pop_front();
    checkCount++;
    if ({bus1.out_valid, bus1.out_data, bus1.out_last, bus1.out_zero} !== {1'b1, e.data, e.last, e.zero})
      $display("[TB] FAIL single_out: got %b/%h/%b/%b required 1/%h/%b/%b",
               bus1.out_valid, bus1.out_data, bus1.out_last, bus1.out_zero, e.data, e.last, e.zero);
    else passCount++;
    @(negedge clk);
    checkCount++;
    if ({bus1.in_ready, bus1.out_valid} !== 2'b10)
      $display("[TB] FAIL single_return: got %b required 10", {bus1.in_ready, bus1.out_valid});
    else passCount++;
  endtask

  task automatic test_no_zero_divide();
    checkCount++;
    if (zeroDiv != 0)
      $display("[TB] FAIL zero_divisor_starts: got %0d required 0", zeroDiv);
    else passCount++;
  endtask

  // Global bound so the run can never hang.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    passCount = 0;
    checkCount = 0;
    reset = 1'b0;
    bus4.in_valid = 1'b0; bus4.in_data = '0; bus4.out_ready = 1'b1;
    bus1.in_valid = 1'b0; bus1.in_data = '0; bus1.out_ready = 1'b1;
    test_reset();
    test_uniform();
    test_mixed();
    test_zero();
    test_stall();
    test_reset_midop();
    test_single();
    test_no_zero_divide();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/capsule_coupling_normalizer.md
Name: capsule_coupling_normalizer

Overview:
Final normalisation stage of the dynamic-routing softmax in the capsule datapath.
- Collects N unsigned exponent values per capsule into a local buffer and accumulates their sum.
- Drives the shared 32-bit sequential divider to produce each coupling coefficient c_i = e_i / sum(e) in unsigned Q16.16.
- Streams the N coefficients out to the routing-weight multiplier, with a last-flag on the final one.

Parameters:
N, 8, entries per capsule group (1..16)
IW, 16, input value width (fixed so that {value,16'b0} fits the 32-bit divider)
FRAC, 16, fraction bits of the quotient (fixed, equals 32-IW)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low; 0 clears all state immediately
in_valid  input  1  input value valid
in_ready  output  1  block accepts input (asserted only in COLLECT)
in_data  input  IW  unsigned exponent value
div_start  output  1  divider start/run (must remain high while the divider iterates)
div_a  output  32  dividend = {buf[idx], 16'b0}
div_b  output  32  divisor = sum, zero-extended
div_d  input  32  divider quotient
div_ok  input  1  divider idle / result ready
out_valid  output  1  coefficient valid
out_ready  input  1  downstream accepts
out_data  output  32  coefficient, Q16.16, at most 0x0001_0000
out_last  output  1  high with the N-th coefficient of a group
out_zero  output  1  group sum was zero; out_data forced to 0

Behaviour:
- Reset values: in_ready=0, div_start=0, out_valid=0, out_data=0, out_last=0, out_zero=0; state=COLLECT, cnt=0, idx=0, sum=0.
- On the first cycle after reset deasserts, in_ready=1.
- Storage: buf[0..N-1] of IW bits; sum register of 32 bits, which cannot overflow for N<=16.
- COLLECT:
  - in_ready=1.
  - On in_valid&&in_ready: buf[cnt]<=in_data, sum<=sum+in_data, cnt++.
  - On accepting the N-th value, go to ISSUE. If the final sum (including that value) is 0, set zflag and go to EMIT instead, with out_data=0 and idx=0.
- ISSUE (1 cycle):
  - div_start=1; div_a and div_b are valid.
  - Go to WAIT.
- WAIT:
  - div_start = ~div_ok, decoded combinationally so the divider does not reload when the result appears.
  - When div_ok=1: capture div_d into out_data and go to EMIT.
  - The first WAIT cycle always sees div_ok=0 because the divider goes busy at the ISSUE edge.
- EMIT:
  - out_valid=1; out_last = (idx==N-1); out_zero = zflag.
  - Hold all outputs stable until out_ready.
  - On handshake, if idx<N-1: idx++, then go to ISSUE, or stay in EMIT with out_data=0 if zflag.
  - On handshake, if idx=N-1: clear cnt, idx, sum and zflag, and go to COLLECT.
- Latency: from ISSUE entry to out_valid is 34 cycles (ISSUE 1, busy 32, ok-capture 1). A group with out_ready held high takes N+34N cycles plus collect time.
- No overlap: in_ready=0 from acceptance of the N-th value until the last coefficient is accepted.
- Zero sum: the divider is never started, and no division by zero reaches the divider.
- out_valid must not drop without a handshake. out_data and out_last must not change while out_valid=1 and out_ready=0.
- Reset mid-operation (any state): all state returns to reset values. The integrator must reset the divider in the same event; the block then assumes div_ok=1 before the next ISSUE.
- N=1: a single value v>0 gives 0x0001_0000.

Test Plan:
- N=4, inputs 1,1,1,1, out_ready=1 → four outputs 0x0000_4000; out_last only on the 4th; 34 cycles from ISSUE to each out_valid.
- N=4, inputs 3,1,0,0 → 0x0000_C000, 0x0000_4000, 0, 0; div_start pulses exactly 4 times.
- N=4, inputs 0,0,0,0 → four outputs 0 with out_zero=1; div_start never asserted.
- N=4, inputs 0xFFFF×4, with out_ready low for 5 cycles on the 2nd output → 0x0000_4000 held stable during the stall; in_ready=0 until the 4th handshake, then 1 on the next cycle.
- Reset asserted during the 10th WAIT cycle of the 2nd division → all outputs 0 immediately, in_ready=1 after release; a new group 2,2,4,0 then yields 0x0000_4000, 0x0000_4000, 0x0000_8000, 0.
- N=1, input 0x1234 → 0x0001_0000 with out_last=1.
